// File: rtl/demux_rr_fifo_tarea34.sv
// demux_rr_fifo_tarea34: splits one 2-bit word stream across two lanes.
// Each lane has its own show-ahead FIFO. The destination lane comes either
// from an internal alternating pointer (rr_sel) or from an external selector.
//
// Handshake: a word is accepted on a rising edge only when valid_in and
// ready_in are both high. ready_in is combinational and is low when the
// chosen lane is full. A word that is not accepted is ignored; the source
// must hold it.
module demux_rr_fifo_tarea34 #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              sel_mode,
    input  logic              selector,
    input  logic              pop0,
    input  logic              pop1,
    output logic [DATA_W-1:0] data_out0,
    output logic              valid_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out1,
    output logic              full0,
    output logic              full1
);

    // Per-lane state. Index 0 is lane0 and index 1 is lane1.
    logic [DATA_W-1:0] mem    [2][DEPTH];
    logic [PTR_W-1:0]  rd_ptr [2];
    logic [PTR_W-1:0]  wr_ptr [2];
    logic [PTR_W:0]    count  [2];

    logic       rr_sel;
    logic       dest;
    logic       accept;
    logic [1:0] full_l;
    logic [1:0] push;
    logic [1:0] pop_ok;

    // Pick the destination lane, then derive the handshake and the
    // per-lane push and pop strobes.
    always_comb begin
        dest      = sel_mode ? selector : rr_sel;
        full_l[0] = (count[0] == (PTR_W+1)'(DEPTH));
        full_l[1] = (count[1] == (PTR_W+1)'(DEPTH));
        ready_in  = reset_L & ~full_l[dest];
        accept    = valid_in & ready_in;
        push[0]   = accept & ~dest;
        push[1]   = accept & dest;
        // A pop is honoured only when the lane holds a word, so popping an
        // empty lane leaves its pointers unchanged.
        pop_ok[0] = pop0 & (count[0] != '0);
        pop_ok[1] = pop1 & (count[1] != '0);
    end

    // Round-robin pointer: toggles only on an accepted word in round-robin
    // mode. A blocked word leaves it unchanged, which gives strict
    // alternation with head-of-line blocking.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_sel <= 1'b0;
        end else if (accept && !sel_mode) begin
            rr_sel <= ~rr_sel;
        end
    end

    // Lane FIFOs: write at the tail, read at the head. Pointers wrap
    // naturally at DEPTH, and a push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= data_in;
                    wr_ptr[i]         <= wr_ptr[i] + 1'b1;
                end
                if (pop_ok[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (push[i] && !pop_ok[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (!push[i] && pop_ok[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
        end
    end

    // Show-ahead outputs: the head word is visible while the lane is
    // non-empty, and the output is forced to zero when the lane is empty.
    always_comb begin
        valid_out0 = (count[0] != '0);
        valid_out1 = (count[1] != '0);
        data_out0  = valid_out0 ? mem[0][rd_ptr[0]] : '0;
        data_out1  = valid_out1 ? mem[1][rd_ptr[1]] : '0;
        full0      = full_l[0];
        full1      = full_l[1];
    end

endmodule

// File: tb/tb_demux_rr_fifo_tarea34.sv
// Directed testbench for demux_rr_fifo_tarea34.
// Inputs change on the falling edge and outputs are sampled away from the
// rising edge. All expected values are written out by hand.
module tb_demux_rr_fifo_tarea34;

    logic       clk;
    logic       reset_L;
    logic [1:0] data_in;
    logic       valid_in;
    logic       ready_in;
    logic       sel_mode;
    logic       selector;
    logic       pop0;
    logic       pop1;
    logic [1:0] data_out0;
    logic       valid_out0;
    logic [1:0] data_out1;
    logic       valid_out1;
    logic       full0;
    logic       full1;

    int total = 0;
    int bad   = 0;

    demux_rr_fifo_tarea34 #(.DATA_W(2), .DEPTH(4), .PTR_W(2)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .sel_mode   (sel_mode),
        .selector   (selector),
        .pop0       (pop0),
        .pop1       (pop1),
        .data_out0  (data_out0),
        .valid_out0 (valid_out0),
        .data_out1  (data_out1),
        .valid_out1 (valid_out1),
        .full0      (full0),
        .full1      (full1)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance through one rising edge and stop on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Set the stream inputs. Called while sitting on a falling edge.
    task automatic drive(input logic v, input logic [1:0] d, input logic sm,
                         input logic sel, input logic p0, input logic p1);
        valid_in = v;
        data_in  = d;
        sel_mode = sm;
        selector = sel;
        pop0     = p0;
        pop1     = p1;
    endtask

    // Hold reset for two cycles with all inputs idle, then release it on a
    // falling edge.
    task automatic do_reset();
        reset_L = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- Reset state, then round-robin distribution ----
        @(negedge clk);
        valid_in = 1'b1;
        #1;
        check("rst_ready", ready_in, 0);
        check("rst_valid0", valid_out0, 0);
        check("rst_valid1", valid_out1, 0);
        check("rst_full0", full0, 0);
        check("rst_data0", data_out0, 0);
        do_reset();
        drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rr_lat_valid0", valid_out0, 1);
        check("rr_lat_data0", data_out0, 2'b01);
        check("rr_lat_valid1", valid_out1, 0);
        data_in = 2'b10; tick();
        data_in = 2'b11; tick();
        data_in = 2'b00; tick();
        valid_in = 1'b0;
        check("rr_data0", data_out0, 2'b01);
        check("rr_data1", data_out1, 2'b10);
        check("rr_valid0", valid_out0, 1);
        check("rr_valid1", valid_out1, 1);
        pop0 = 1'b1; pop1 = 1'b1; tick();
        pop0 = 1'b0; pop1 = 1'b0;
        check("rr_second0", data_out0, 2'b11);
        check("rr_second1", data_out1, 2'b00);

        // ---- External select: fill lane1, one word blocked until a pop ----
        do_reset();
        drive(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        data_in = 2'b10; tick();
        data_in = 2'b01; tick();
        data_in = 2'b00; tick();
        data_in = 2'b11;
        #1;
        check("ext_full1", full1, 1);
        check("ext_ready_blocked", ready_in, 0);
        check("ext_lane0_empty", valid_out0, 0);
        tick();
        check("ext_still_full", full1, 1);
        check("ext_head1", data_out1, 2'b11);
        pop1 = 1'b1;
        tick();
        pop1 = 1'b0;
        #1;
        check("ext_after_pop_full", full1, 0);
        check("ext_after_pop_ready", ready_in, 1);
        check("ext_after_pop_head", data_out1, 2'b10);
        tick();
        valid_in = 1'b0;
        check("ext_refull", full1, 1);
        pop1 = 1'b1;
        check("ext_drain0", data_out1, 2'b10); tick();
        check("ext_drain1", data_out1, 2'b01); tick();
        check("ext_drain2", data_out1, 2'b00); tick();
        check("ext_drain3", data_out1, 2'b11); tick();
        pop1 = 1'b0;
        check("ext_drained_valid", valid_out1, 0);
        check("ext_drained_data", data_out1, 0);

        // ---- Head-of-line block on a full lane0 ----
        do_reset();
        drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        data_in = 2'b10; tick();
        data_in = 2'b11; tick();
        data_in = 2'b00; tick();
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("hol_full0", full0, 1);
        check("hol_ready", ready_in, 0);
        tick();
        tick();
        check("hol_lane1_empty", valid_out1, 0);
        pop0 = 1'b1;
        tick();
        pop0 = 1'b0;
        #1;
        check("hol_ready_again", ready_in, 1);
        tick();
        check("hol_into_lane0", full0, 1);
        check("hol_lane1_still_empty", valid_out1, 0);
        data_in = 2'b10;
        tick();
        valid_in = 1'b0;
        check("hol_next_lane1_valid", valid_out1, 1);
        check("hol_next_lane1_data", data_out1, 2'b10);
        check("hol_head0", data_out0, 2'b10);

        // ---- Push and pop on the same edge ----
        do_reset();
        drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        data_in = 2'b10; tick();
        data_in = 2'b11; pop0 = 1'b1;
        tick();
        valid_in = 1'b0;
        check("sim_head", data_out0, 2'b10);
        check("sim_not_full", full0, 0);
        tick();
        check("sim_tail", data_out0, 2'b11);
        check("sim_valid", valid_out0, 1);
        tick();
        pop0 = 1'b0;
        check("sim_empty", valid_out0, 0);

        // ---- Pop when empty, then push with 1-cycle latency ----
        do_reset();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("pe_valid0", valid_out0, 0);
        check("pe_data0", data_out0, 0);
        check("pe_valid1", valid_out1, 0);
        drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        valid_in = 1'b0;
        check("pe_push_valid", valid_out0, 1);
        check("pe_push_data", data_out0, 2'b10);

        // ---- Asynchronous reset mid-stream ----
        do_reset();
        drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        data_in = 2'b10; tick();
        data_in = 2'b11; tick();
        valid_in = 1'b0;
        check("ar_pre_valid1", valid_out1, 1);
        #2;
        reset_L = 1'b0;
        #1;
        check("ar_valid0", valid_out0, 0);
        check("ar_valid1", valid_out1, 0);
        check("ar_full0", full0, 0);
        check("ar_full1", full1, 0);
        check("ar_ready", ready_in, 0);
        check("ar_data0", data_out0, 0);
        @(negedge clk);
        reset_L = 1'b1;
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        valid_in = 1'b0;
        check("ar_restart_lane0", valid_out0, 1);
        check("ar_restart_data0", data_out0, 2'b11);
        check("ar_restart_lane1", valid_out1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_rr_fifo_tarea34.md
Name: demux_rr_fifo_tarea34

Overview:
- Inverse of the tarea34 2:1 mux path: takes one registered 2-bit stream and distributes words to two output lanes.
- Destination is chosen by internal round-robin (alternating) or by an external selector.
- Each lane has its own small show-ahead FIFO so downstream consumers can drain independently.
- Sits after the mux/flop stage, feeding two lane consumers.

Parameters:
- DATA_W, 2, width of each data word
- DEPTH, 4, entries per lane FIFO (power of 2, >=2)
- PTR_W, 2, log2(DEPTH); pointer width

Ports:
- clk  input  1  rising-edge clock
- reset_L  input  1  asynchronous active-low reset
- data_in  input  DATA_W  incoming word
- valid_in  input  1  data_in valid this cycle
- ready_in  output  1  block can accept data_in this cycle (combinational)
- sel_mode  input  1  0 = round-robin, 1 = external select
- selector  input  1  destination lane when sel_mode=1 (0 -> lane0, 1 -> lane1)
- pop0  input  1  consume head of lane0
- pop1  input  1  consume head of lane1
- data_out0  output  DATA_W  head of lane0 FIFO
- valid_out0  output  1  lane0 non-empty
- data_out1  output  DATA_W  head of lane1 FIFO
- valid_out1  output  1  lane1 non-empty
- full0  output  1  lane0 holds DEPTH words
- full1  output  1  lane1 holds DEPTH words

Behaviour:
Reset (reset_L=0, asynchronous, immediate):
- FIFO counts, read/write pointers and storage cleared to 0.
- rr_sel = 0.
- Outputs: valid_out0/1=0, data_out0/1=0, full0/1=0.
- ready_in=0 while reset_L=0.
- Reset mid-stream discards all buffered words.

Destination selection:
- dest = sel_mode ? selector : rr_sel.

Handshake:
- ready_in = reset_L & ~full[dest].
- Accept occurs on a rising edge when valid_in & ready_in; data_in is written to FIFO[dest].
- No accept -> nothing is written; data_in is ignored.

Round-robin state:
- rr_sel toggles on each accept only while sel_mode=0.
- With sel_mode=1, rr_sel holds its value.
- After returning to sel_mode=0, distribution resumes from the held rr_sel.
- A blocked word (dest full) does not toggle rr_sel and is not redirected to the other lane. This gives strict alternation with head-of-line blocking.

FIFO (per lane, independent):
- Show-ahead: data_out = storage[rd_ptr] when non-empty; data_out = 0 when empty.
- valid_out = (count != 0); full = (count == DEPTH).
- Pop: pop with valid_out=1 advances rd_ptr and decrements count on the edge. Pop when empty is ignored (no underflow, pointers unchanged).
- Push and valid pop on the same lane in the same edge: count unchanged, both pointers advance.
- When full, ready_in is low, so no push. A pop on that edge still frees one entry; ready_in rises the next cycle.
- Pointers wrap modulo DEPTH.
- count is PTR_W+1 bits wide.

Latency:
- A word accepted at edge N appears on data_out/valid_out of its lane immediately after edge N, i.e. usable in cycle N+1.
- If the lane was empty, it is at the head with 1-cycle latency.

Ordering:
- Words keep their arrival order within each lane.
- No ordering relation is defined across lanes.

Test Plan:
- Reset then round-robin: release reset_L, sel_mode=0, send 2'b01, 2'b10, 2'b11, 2'b00 on 4 consecutive cycles, no pops -> lane0 holds 01,11 and lane1 holds 10,00; data_out0=01, data_out1=10, valid_out0=valid_out1=1.
- External select, fill lane1: sel_mode=1, selector=1, push 5 words (11,10,01,00,11) -> first 4 accepted; full1=1 and ready_in=0 on the 5th; the 5th is held until pop1. Pop1 one cycle -> ready_in=1 next cycle, 5th accepted. Draining yields 10,01,00,11.
- Head-of-line block: lane0 full, rr_sel=0, valid_in=1 -> ready_in=0, rr_sel stays 0, lane1 receives nothing even though empty.
- Simultaneous push/pop: lane0 count=2, push and pop0 on the same edge -> count stays 2, head advances to the next word, new word queued at tail.
- Pop when empty: pop0=pop1=1 with both lanes empty -> valid_out=0, data_out=0, pointers unchanged. Next push lands at the head with 1-cycle latency.
- Asynchronous reset mid-stream: with 3 words buffered, assert reset_L=0 between edges -> valid_out0/1, full0/1 and ready_in go to 0 immediately. After release, round-robin restarts at lane0.
